edge_event_arbiter: RTL

Multi-channel edge-event scheduler. Each of `NUM_CH` asynchronous input lines is synchronised and edge-detected, and each detected edge is latched as a pending event. A round-robin arbiter then offers the pending events one at a time to a single downstream consumer over a valid/ready handshake. It sits between raw status/trigger lines and the single event-handling path (interrupt logic, timestamp capture, register-block event FIFO).

---
 rtl/edge_event_arbiter_pkg.sv | 27 ++
 rtl/edge_event_arbiter_if.sv | 20 ++
 rtl/edge_event_arbiter_sync_detect.sv | 39 +++
 rtl/edge_event_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/edge_event_arbiter_pkg.sv
// Shared constants, FSM state encoding and elaboration helpers for the
// edge event arbiter.
package edge_event_pkg;

    // Edge-type encodings selected from the EDGE_TYPE string at the top level
    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_BOTH = 2'd2;

    // Arbiter FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_OFFER = 1'b1;

    // Ceiling log2, used to validate IDX_WIDTH against NUM_CH
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event offer handshake between the arbiter and its single consumer.
interface edge_event_arbiter_if #(
    parameter int IDX_WIDTH = 3
);
    logic                 evt_valid;
    logic                 evt_ready;
    logic [IDX_WIDTH-1:0] evt_idx;

    modport master (
        output evt_valid,
        output evt_idx,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_arbiter_sync_detect.sv
// One channel: two-flop synchroniser, history flop and edge detect.
module edge_sync_detect
    import edge_event_pkg::*;
#(
    parameter logic [1:0] EDGE_SEL = EDGE_RISE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic det_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchronise the raw line and keep one cycle of history for the detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= line_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Edge select is a constant; only one branch survives elaboration
    always_comb begin
        case (EDGE_SEL)
            EDGE_FALL: det_o = ~s2_q & s3_q;
            EDGE_BOTH: det_o = s2_q ^ s3_q;
            default:   det_o = s2_q & ~s3_q;
        endcase
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge event scheduler: latches detected edges as pending
// events and offers them one at a time, round robin, over valid/ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing offered; load the round-robin winner when pending
// ST_OFFER | evt_idx offered; on accept load next winner or fall idle
module edge_event_arbiter
    import edge_event_pkg::*;
#(
    parameter int    NUM_CH    = 8,
    parameter int    IDX_WIDTH = 3,
    parameter string EDGE_TYPE = "RISE"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_CH-1:0]    in,
    input  logic                 ovf_clr,
    output logic [NUM_CH-1:0]    pending,
    output logic [NUM_CH-1:0]    ovf,
    edge_event_arbiter_if.master evt
);

    localparam logic [1:0] EDGE_SEL = (EDGE_TYPE == "FALL") ? EDGE_FALL :
                                      (EDGE_TYPE == "BOTH") ? EDGE_BOTH : EDGE_RISE;

    if (IDX_WIDTH != clog2_f(NUM_CH)) begin : g_bad_idx_width
        $error("edge_event_arbiter: IDX_WIDTH must equal clog2(NUM_CH)");
    end
    if (NUM_CH < 2 || NUM_CH > 32) begin : g_bad_num_ch
        $error("edge_event_arbiter: NUM_CH must be in 2..32");
    end

    logic [NUM_CH-1:0]    det;
    logic [NUM_CH-1:0]    det_g;
    logic [NUM_CH-1:0]    clr;
    logic [NUM_CH-1:0]    pending_q, pending_d;
    logic [NUM_CH-1:0]    ovf_q, ovf_d;
    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0] evt_idx_q, evt_idx_d;
    logic [IDX_WIDTH-1:0] win_idx;
    logic                 win_found;
    logic                 load;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        edge_sync_detect #(
            .EDGE_SEL (EDGE_SEL)
        ) u_sync_detect (
            .clk    (clk),
            .rst_n  (rst_n),
            .line_i (in[g]),
            .det_o  (det[g])
        );
    end

    assign det_g = det & {NUM_CH{en}};

    // Round-robin search starting one past the last granted channel
    always_comb begin
        int                   cand;
        logic [IDX_WIDTH-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand     = (int'(rr_ptr_q) + k) % NUM_CH;
            cand_idx = IDX_WIDTH'(cand);
            if (!win_found && pending_q[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Offer FSM; a load both grants the winner and advances the pointer
    always_comb begin
        state_d   = state_q;
        evt_idx_d = evt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    load    = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt.evt_ready) begin
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            evt_idx_d = win_idx;
            rr_ptr_d  = win_idx;
        end
    end

    // A fresh detect outranks the grant clear; a detect on an already
    // pending channel that is not being granted is coalesced into ovf
    always_comb begin
        clr       = load ? ({{(NUM_CH-1){1'b0}}, 1'b1} << win_idx) : '0;
        pending_d = (pending_q & ~clr) | det_g;
        ovf_d     = (ovf_clr ? '0 : ovf_q) | (det_g & pending_q & ~clr);
    end

    // State, pointer, output and event registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= IDX_WIDTH'(NUM_CH - 1);
            evt_idx_q <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            evt_idx_q <= evt_idx_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign evt.evt_valid = (state_q == ST_OFFER);
    assign evt.evt_idx   = evt_idx_q;
    assign pending       = pending_q;
    assign ovf           = ovf_q;

endmodule
